// File: rtl/tdm_demux_pkg.sv
// Shared types and defaults for the TDM receive demultiplexer.
// Compile-time option TDM_STRICT_SYNC_EN is consumed by tdm_demux4.
package tdm_demux_pkg;

  typedef enum logic {HUNT, LOCK} tdm_state_t;

  localparam int DEFAULT_N_CH = 4;

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-N_CH slot counter for the TDM demux. It can be cleared to 0, loaded
// to 1 (right after a sync bit lands in slot 0), or advanced.
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = DEFAULT_N_CH,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load1,
  input  logic             clr,
  output logic [SEL_W-1:0] slot,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  assign wrap = (slot == LAST);

  // Clear wins over load, and load wins over a plain advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SEL_W'(1);
    end else if (en) begin
      slot <= wrap ? '0 : slot + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// TDM serial-to-channel demultiplexer with frame assembly and sync checking.
// Define TDM_STRICT_SYNC_EN to drop lock when sync is missing at slot 0.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = DEFAULT_N_CH,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [N_CH-1:0]  ch_out,
  output logic [N_CH-1:0]  ch_valid,
  output logic [SEL_W-1:0] slot,
  output logic [N_CH-1:0]  frame_q,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  tdm_state_t      state;
  logic [N_CH-1:0] shadow;
  logic [N_CH-1:0] shadow_nxt;
  logic [N_CH-1:0] slot_hot;
  logic [N_CH-1:0] first_hot;
  logic [N_CH-1:0] first_bit;
  logic            wrap;
  logic            hunt_start;
  logic            early_sync;
  logic            strict_drop;
  logic            normal;

  assign hunt_start = (state == HUNT) && din_valid && frame_sync;
  assign early_sync = (state == LOCK) && din_valid && frame_sync && (slot != '0);

`ifdef TDM_STRICT_SYNC_EN
  assign strict_drop = (state == LOCK) && din_valid && !frame_sync && (slot == '0);
`else
  assign strict_drop = 1'b0;
`endif

  assign normal    = (state == LOCK) && din_valid && !early_sync && !strict_drop;
  assign first_hot = {{(N_CH-1){1'b0}}, 1'b1};
  assign first_bit = {{(N_CH-1){1'b0}}, din};
  assign slot_hot  = first_hot << slot;

  always_comb begin
    shadow_nxt       = shadow;
    shadow_nxt[slot] = din;
  end

  tdm_slot_counter #(.N_CH(N_CH)) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (normal),
    .load1 (hunt_start || early_sync),
    .clr   (strict_drop),
    .slot  (slot),
    .wrap  (wrap)
  );

  // A sync bit (from HUNT, or early in LOCK) restarts the frame at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      ch_out      <= '0;
      ch_valid    <= '0;
      frame_q     <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      shadow      <= '0;
    end else begin
      ch_valid    <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (hunt_start || early_sync) begin
        ch_out[0] <= din;
        ch_valid  <= first_hot;
        shadow    <= first_bit;
        state     <= LOCK;
        locked    <= 1'b1;
        sync_err  <= early_sync;
      end else if (strict_drop) begin
        sync_err <= 1'b1;
        state    <= HUNT;
        locked   <= 1'b0;
        shadow   <= '0;
      end else if (normal) begin
        ch_out[slot] <= din;
        ch_valid     <= slot_hot;
        shadow       <= shadow_nxt;
        if (wrap) begin
          frame_q     <= shadow_nxt;
          frame_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: directed bits push expected output events,
// a negedge monitor pops and compares them. Honors TDM_STRICT_SYNC_EN.
module tb_tdm_demux4;

  typedef struct packed {
    logic [3:0] cv;
    logic [3:0] co;
    logic [3:0] fq;
    logic       fv;
    logic       se;
    logic       lk;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic [3:0] ch_out;
  logic [3:0] ch_valid;
  logic [1:0] slot;
  logic [3:0] frame_q;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;

  ev_t exp_q[$];
  ev_t mon_act;
  ev_t mon_exp;
  int  vectors = 0;
  int  miscompares = 0;

`ifdef TDM_STRICT_SYNC_EN
  localparam logic [3:0] FQ6 = 4'b1100;
`else
  localparam logic [3:0] FQ6 = 4'b1101;
`endif

  tdm_demux4 #(.N_CH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .ch_out      (ch_out),
    .ch_valid    (ch_valid),
    .slot        (slot),
    .frame_q     (frame_q),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n === 1'b1 && din_valid === 1'b1)
      assert (!$isunknown(frame_sync)) else $error("[TB] frame_sync unknown while din_valid high");
  end

  // Any pulse on the outputs is an event that must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (ch_valid !== 4'b0 || frame_valid !== 1'b0 || sync_err !== 1'b0) begin
        mon_act = {ch_valid, ch_out, frame_q, frame_valid, sync_err, locked};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_event got cv=%b co=%b fq=%b fv=%b se=%b lk=%b, expected no event",
                   mon_act.cv, mon_act.co, mon_act.fq, mon_act.fv, mon_act.se, mon_act.lk);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            miscompares++;
            $display("[TB] FAIL event got cv=%b co=%b fq=%b fv=%b se=%b lk=%b, expected cv=%b co=%b fq=%b fv=%b se=%b lk=%b",
                     mon_act.cv, mon_act.co, mon_act.fq, mon_act.fv, mon_act.se, mon_act.lk,
                     mon_exp.cv, mon_exp.co, mon_exp.fq, mon_exp.fv, mon_exp.se, mon_exp.lk);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic d, input logic fs, input logic [3:0] cv,
                               input logic [3:0] co, input logic [3:0] fq,
                               input logic fv, input logic se, input logic lk);
    ev_t e;
    @(posedge clk);
    #1;
    din        = d;
    frame_sync = fs;
    din_valid  = 1'b1;
    e = {cv, co, fq, fv, se, lk};
    if (cv != 4'b0 || fv || se) exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      din_valid  = 1'b0;
      din        = 1'b1;
      frame_sync = 1'b1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] co, input logic [3:0] fq,
                             input logic lk, input logic [1:0] sl);
    vectors++;
    if ({ch_out, ch_valid, frame_q, frame_valid, locked, sync_err, slot} !==
        {co, 4'b0, fq, 1'b0, lk, 1'b0, sl}) begin
      miscompares++;
      $display("[TB] FAIL %s got co=%b cv=%b fq=%b fv=%b lk=%b se=%b slot=%0d, expected co=%b cv=0000 fq=%b fv=0 lk=%b se=0 slot=%0d",
               name, ch_out, ch_valid, frame_q, frame_valid, locked, sync_err, slot, co, fq, lk, sl);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 4'b0000, 4'b0000, 1'b0, 2'd0);
    rst_n = 1'b1;

    $display("[TB] basic frame with sync on first bit");
    applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'b0100, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b1000, 4'b1010, 4'b1010, 1'b1, 1'b0, 1'b1);
    idle(2);
    checkOutput("frame1", 4'b1010, 4'b1010, 1'b1, 2'd0);

    rst_n = 1'b0;
    #1;
    checkOutput("reset2", 4'b0000, 4'b0000, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] unsynced bits discarded in HUNT");
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    idle(2);
    checkOutput("hunt_discard", 4'b0000, 4'b0000, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'b0010, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'b0100, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b1000, 4'b1001, 4'b1001, 1'b1, 1'b0, 1'b1);

    $display("[TB] din_valid gap mid-frame");
    applyStimulus(1'b0, 1'b1, 4'b0001, 4'b1000, 4'b1001, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0010, 4'b1010, 4'b1001, 1'b0, 1'b0, 1'b1);
    idle(3);
    checkOutput("gap_hold", 4'b1010, 4'b1001, 1'b1, 2'd2);
    applyStimulus(1'b1, 1'b0, 4'b0100, 4'b1110, 4'b1001, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'b1000, 4'b0110, 4'b0110, 1'b1, 1'b0, 1'b1);

    $display("[TB] early sync at slot 2");
    applyStimulus(1'b1, 1'b1, 4'b0001, 4'b0111, 4'b0110, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0010, 4'b0111, 4'b0110, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0110, 4'b0110, 1'b0, 1'b1, 1'b1);
    idle(2);
    checkOutput("early_sync", 4'b0110, 4'b0110, 1'b1, 2'd1);
    applyStimulus(1'b0, 1'b0, 4'b0010, 4'b0100, 4'b0110, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0100, 4'b0110, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b1000, 4'b1100, 4'b1100, 1'b1, 1'b0, 1'b1);

    $display("[TB] frame without sync at slot 0");
`ifdef TDM_STRICT_SYNC_EN
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1100, 4'b1100, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1100, 4'b1100, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1100, 4'b1100, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1100, 4'b1100, 1'b0, 1'b0, 1'b0);
    idle(2);
    checkOutput("strict_drop", 4'b1100, 4'b1100, 1'b0, 2'd0);
`else
    applyStimulus(1'b1, 1'b0, 4'b0001, 4'b1101, 4'b1100, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'b0010, 4'b1101, 4'b1100, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0100, 4'b1101, 4'b1100, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b1000, 4'b1101, 4'b1101, 1'b1, 1'b0, 1'b1);
    idle(2);
    checkOutput("flywheel", 4'b1101, 4'b1101, 1'b1, 2'd0);
`endif

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(1'b0, 1'b1, 4'b0001, 4'b1100, FQ6, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0010, 4'b1110, FQ6, 1'b0, 1'b0, 1'b1);
    idle(2);
    checkOutput("pre_reset", 4'b1110, FQ6, 1'b1, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 4'b0000, 4'b0000, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    idle(2);
    checkOutput("post_reset_hunt", 4'b0000, 4'b0000, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain got %0d pending events, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
